// File: rtl/fp_pkg.sv
// Shared types and constants for the FP mult/div result path.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
    } fp_flags_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_word_t;

    typedef struct packed {
        fp_word_t  word;
        fp_flags_t flags;
    } fp_entry_t;

endpackage

// File: rtl/fp_result_fifo.sv
// First-word-fall-through FIFO of packed results plus their exception flags.
module fp_result_fifo
    import fp_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          push,
    input  fp_word_t      push_word,
    input  fp_flags_t     push_flags,
    input  logic          pop,
    output fp_word_t      rd_word,
    output fp_flags_t     rd_flags,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fp_entry_t     mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;
    fp_entry_t     rd_entry;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= '{word: push_word, flags: push_flags};
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Outputs read as zero while empty so stale entries never leak after reset.
    assign rd_entry = empty ? '0 : mem_reg[rd_ptr_reg];
    assign rd_word  = rd_entry.word;
    assign rd_flags = rd_entry.flags;

endmodule

// File: rtl/fp_result_packer.sv
// Output stage of the FP mult/div pipeline: token tracking, IEEE-754 packing, result FIFO.
// Optional sticky flag accumulation is enabled by defining FP_PACKER_STICKY_EN.
module fp_result_packer
    import fp_pkg::*;
#(
    parameter int LATENCY = 23,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        issue_i,
    output logic        en_o,
    input  logic        s_r_i,
    input  logic [9:0]  exp_i,
    input  logic [23:0] man_i,
    input  logic        nan_i,
    input  logic        inf_i,
    input  logic        zero_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic [2:0]  out_flags_o,
    input  logic        clr_flags_i,
    output logic [2:0]  sticky_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic signed [9:0] EXP_OVF = 10'(2 * BIAS + 1);

    logic [LATENCY-1:0] tok_reg;
    logic               push;
    logic               pop;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    fp_word_t           pack_word;
    fp_flags_t          pack_flags;
    fp_word_t           fifo_word;
    fp_flags_t          fifo_flags;
    logic signed [9:0]  exp_s;
    logic               unused_hidden;

    // A popped slot frees room in the same edge, so pop keeps the pipeline moving when full.
    assign pop  = out_valid_o & out_ready_i;
    assign en_o = (fifo_count < CW'(DEPTH)) | pop;
    assign push = en_o & tok_reg[0];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tok_reg <= '0;
        end else if (en_o) begin
            tok_reg <= {issue_i, tok_reg[LATENCY-1:1]};
        end
    end

    assign exp_s         = $signed(exp_i);
    assign unused_hidden = man_i[MAN_W];

    always_comb begin
        pack_word  = '0;
        pack_flags = '0;
        if (nan_i) begin
            pack_word          = fp_word_t'(QNAN);
            pack_flags.invalid = 1'b1;
        end else if (inf_i) begin
            pack_word.sign = s_r_i;
            pack_word.exp  = '1;
        end else if (zero_i) begin
            pack_word.sign = s_r_i;
        end else if (exp_s >= EXP_OVF) begin
            pack_word.sign      = s_r_i;
            pack_word.exp       = '1;
            pack_flags.overflow = 1'b1;
        end else if (exp_s <= 10'sd0) begin
            // Flush to zero: no subnormal encoding is produced.
            pack_word.sign       = s_r_i;
            pack_flags.underflow = 1'b1;
        end else begin
            pack_word.sign = s_r_i;
            pack_word.exp  = exp_i[EXP_W-1:0];
            pack_word.man  = man_i[MAN_W-1:0];
        end
    end

    fp_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .arst       (arst),
        .push       (push),
        .push_word  (pack_word),
        .push_flags (pack_flags),
        .pop        (pop),
        .rd_word    (fifo_word),
        .rd_flags   (fifo_flags),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign out_valid_o = ~fifo_empty;
    assign out_data_o  = fifo_word;
    assign out_flags_o = fifo_flags;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!arst) begin
            assert (!(push && fifo_full && !pop));
        end
    end
`endif

`ifdef FP_PACKER_STICKY_EN
    fp_flags_t sticky_reg;

    // A clear drops history but still keeps whatever flags are popped in the same cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sticky_reg <= '0;
        end else if (clr_flags_i) begin
            sticky_reg <= pop ? fifo_flags : '0;
        end else if (pop) begin
            sticky_reg <= fp_flags_t'(sticky_reg | fifo_flags);
        end
    end

    assign sticky_o = sticky_reg;
`else
    logic unused_clr;
    assign unused_clr = clr_flags_i;
    assign sticky_o   = '0;
`endif

endmodule
